// File: rtl/dili_pkg.sv
// dili_pkg: shared FSM encoding and Dilithium arithmetic defaults
package dili_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int Q = 8380417;
  localparam int QINV = 58728449;
  localparam int N = 256;
  localparam int ADDR_W = $clog2(N);
endpackage

// File: rtl/dili_pointwise_mont_ctrl_if.sv
// dili_pointwise_mont_ctrl_if: start/done handshake plus operand-read and result-write ports
interface dili_pointwise_mont_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = dili_pkg::ADDR_W
);
  logic start_i, busy_o, done_o, rd_en_o, wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
  logic signed [WIDTH-1:0] a_rdata_i, b_rdata_i, wr_data_o;
  modport master (
    input start_i, a_rdata_i, b_rdata_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
  modport slave (
    output start_i, a_rdata_i, b_rdata_i,
    input busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/dili_montgomery_reduce.sv
// dili_montgomery_reduce: combinational signed Montgomery reduction, r = p * 2^-WIDTH mod Q in (-Q, Q)
module dili_montgomery_reduce #(
  parameter int WIDTH = 32,
  parameter int QINV = dili_pkg::QINV,
  parameter int Q = dili_pkg::Q
) (
  input  logic signed [2*WIDTH-1:0] p,
  output logic signed [WIDTH-1:0]   r
);
  logic signed [WIDTH-1:0] t;
  logic signed [2*WIDTH-1:0] d;
  assign t = WIDTH'(p[WIDTH-1:0] * WIDTH'(QINV));
  // low WIDTH bits of d are zero by construction, so the shift is exact
  assign d = p - (2*WIDTH)'(t) * (2*WIDTH)'(Q);
  assign r = WIDTH'(d >>> WIDTH);
endmodule

// File: rtl/dili_pointwise_mont_ctrl.sv
// dili_pointwise_mont_ctrl: streams N operand pairs from external RAMs through a
// 3-cycle multiply/Montgomery-reduce pipeline and writes the results back in order.
module dili_pointwise_mont_ctrl #(
  parameter int WIDTH = 32,
  parameter int Q = dili_pkg::Q,
  parameter int QINV = dili_pkg::QINV,
  parameter int N = dili_pkg::N,
  parameter int ADDR_W = dili_pkg::ADDR_W
) (
  input logic clk_i,
  input logic rst_ni,
  dili_pointwise_mont_ctrl_if.master bus
);
  import dili_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  state_t state;
  logic busy, done, rd_en, wr_en, s1_v, p_v;
  logic [ADDR_W-1:0] rd_addr, wr_addr, s1_addr, p_addr;
  logic signed [2*WIDTH-1:0] p;
  logic signed [WIDTH-1:0] r, wr_data;
  dili_montgomery_reduce #(.WIDTH(WIDTH), .QINV(QINV), .Q(Q)) u_reduce (.p(p), .r(r));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          state   <= RUN;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
        end
        RUN: if (rd_addr == LAST) begin
          state <= DRAIN;
          rd_en <= 1'b0;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
        DRAIN: if (wr_en && wr_addr == LAST) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // each stage carries its own valid/address so writes only follow issued reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v    <= 1'b0;
      s1_addr <= '0;
      p_v     <= 1'b0;
      p_addr  <= '0;
      p       <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      s1_v    <= rd_en;
      s1_addr <= rd_addr;
      p_v     <= s1_v;
      p_addr  <= s1_addr;
      if (s1_v) p <= (2*WIDTH)'(bus.a_rdata_i) * (2*WIDTH)'(bus.b_rdata_i);
      wr_en   <= p_v;
      wr_addr <= p_addr;
      if (p_v) wr_data <= r;
    end
  end
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.rd_en_o   = rd_en;
  assign bus.rd_addr_o = rd_addr;
  assign bus.wr_en_o   = wr_en;
  assign bus.wr_addr_o = wr_addr;
  assign bus.wr_data_o = wr_data;
endmodule
